// File: rtl/um_sort_reader_pkg.sv
// ---------------------------------------------------------------------------
// um_sort_reader_pkg
// Shared parameter header for the unified-memory (UM) sort reader.
// Holds the default geometry of the UM (element width and count, plus the
// matching index widths) and the sort-reader FSM state encoding.
// ---------------------------------------------------------------------------
package um_sort_reader_pkg;

  localparam int DATA_WIDTH       = 8;   // element width in bits
  localparam int ELEMENT_NUM      = 16;  // number of UM entries
  localparam int LOG2_ELEMENT_NUM = 4;   // width of an element index
  localparam int LOG2_DATA_WIDTH  = 3;   // width of a bit-plane index

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SCAN = 3'd1,
    LOAD = 3'd2,
    EMIT = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/um_lsb_enc.sv
// ---------------------------------------------------------------------------
// um_lsb_enc
// Lowest-set-bit priority encoder. Returns the index of the lowest set bit
// of vec; an all-zero vec returns index 0.
// Ports:
//   vec  in   WIDTH   candidate vector
//   idx  out  IDX_W   index of the lowest set bit
// ---------------------------------------------------------------------------
module um_lsb_enc #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 4
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx
);

  // NOTE: every output of an always_comb gets a default before any
  // conditional assignment, otherwise synthesis infers a latch.
  always_comb begin
    idx = '0;
    // Walk from the top down so the lowest set bit is the last one written.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/um_sort_reader.sv
// ---------------------------------------------------------------------------
// um_sort_reader
// Reads every UM entry out in ascending signed order (ties by ascending
// index) using a bit-serial minimum search over the UM bit-planes.
// Each search walks the bit-planes MSB to LSB, narrowing a candidate mask to
// the entries holding a 0 in that plane (the UM inverts the MSB plane, so a
// 0 there marks a negative value). The surviving lowest index is then read
// as a whole word and offered on a valid/ready output.
// Ports:
//   clk        in   1                 clock, rising edge
//   rst        in   1                 synchronous active-low reset
//   start      in   1                 begin readout (accepted only in IDLE)
//   bit_data   in   ELEMENT_NUM       UM bit-plane selected by bit_addr
//   um_data    in   DATA_WIDTH        UM word selected by um_addr
//   bit_addr   out  LOG2_DATA_WIDTH   bit-plane select
//   um_addr    out  LOG2_ELEMENT_NUM  word select
//   out_valid  out  1                 out_data/out_idx hold the next element
//   out_ready  in   1                 consumer accepts the element
//   out_data   out  DATA_WIDTH        sorted element value
//   out_idx    out  LOG2_ELEMENT_NUM  UM index of out_data
//   busy       out  1                 not IDLE
//   done       out  1                 one-cycle pulse after the last transfer
// ---------------------------------------------------------------------------
module um_sort_reader
  import um_sort_reader_pkg::*;
#(
  parameter int DATA_WIDTH       = um_sort_reader_pkg::DATA_WIDTH,
  parameter int ELEMENT_NUM      = um_sort_reader_pkg::ELEMENT_NUM,
  parameter int LOG2_ELEMENT_NUM = um_sort_reader_pkg::LOG2_ELEMENT_NUM,
  parameter int LOG2_DATA_WIDTH  = um_sort_reader_pkg::LOG2_DATA_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [ELEMENT_NUM-1:0]      bit_data,
  input  logic [DATA_WIDTH-1:0]       um_data,
  output logic [LOG2_DATA_WIDTH-1:0]  bit_addr,
  output logic [LOG2_ELEMENT_NUM-1:0] um_addr,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic [LOG2_ELEMENT_NUM-1:0] out_idx,
  output logic                        busy,
  output logic                        done
);

  localparam int CNT_W = LOG2_ELEMENT_NUM + 1;

  state_t                  state, state_nxt;
  logic [ELEMENT_NUM-1:0]  mask;       // candidates still in the running
  logic [ELEMENT_NUM-1:0]  remaining;  // entries not yet emitted
  logic [ELEMENT_NUM-1:0]  cand;
  logic [ELEMENT_NUM-1:0]  mask_upd;
  logic [ELEMENT_NUM-1:0]  idx_onehot;
  logic [CNT_W-1:0]        count;
  logic [LOG2_ELEMENT_NUM-1:0] lsb_idx;
  logic                    xfer;
  logic                    last_bit;
  logic                    last_elem;

  // Keep only candidates with a 0 in this plane; if none has one, they all
  // tie on this bit and the mask stays as it was.
  assign cand       = mask & ~bit_data;
  assign mask_upd   = (cand != '0) ? cand : mask;
  assign idx_onehot = ELEMENT_NUM'(1) << out_idx;

  // out_valid is only ever set in EMIT, so it qualifies the handshake alone.
  assign xfer      = out_valid && out_ready;
  assign last_bit  = (bit_addr == '0);
  assign last_elem = (count == CNT_W'(ELEMENT_NUM - 1));

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  um_lsb_enc #(
    .WIDTH (ELEMENT_NUM),
    .IDX_W (LOG2_ELEMENT_NUM)
  ) u_lsb_enc (
    .vec (mask_upd),
    .idx (lsb_idx)
  );

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (last_bit) state_nxt = LOAD;
      LOAD:    state_nxt = EMIT;
      EMIT:    if (xfer) state_nxt = last_elem ? DONE : SCAN;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mask      <= '0;
      remaining <= '0;
      count     <= '0;
      bit_addr  <= '0;
      um_addr   <= '0;
      out_data  <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            mask      <= '1;
            remaining <= '1;
            count     <= '0;
            bit_addr  <= LOG2_DATA_WIDTH'(DATA_WIDTH - 1);
          end
        end
        SCAN: begin
          mask <= mask_upd;
          if (last_bit) um_addr  <= lsb_idx;
          else          bit_addr <= bit_addr - 1'b1;
        end
        LOAD: begin
          out_data  <= um_data;
          out_idx   <= um_addr;
          out_valid <= 1'b1;
        end
        EMIT: begin
          if (xfer) begin
            remaining <= remaining & ~idx_onehot;
            count     <= count + 1'b1;
            out_valid <= 1'b0;
            if (!last_elem) begin
              mask     <= remaining & ~idx_onehot;
              bit_addr <= LOG2_DATA_WIDTH'(DATA_WIDTH - 1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/um_sort_reader.md
UM_SORT_READER -- requirements
Module: um_sort_reader

Interface
REQ-001 SHALL take parameter DATA_WIDTH, default 8 (from shared header), element width in bits.
REQ-002 SHALL take parameter ELEMENT_NUM, default 16, number of UM entries.
REQ-003 SHALL take parameter LOG2_ELEMENT_NUM, default 4, width of element index.
REQ-004 SHALL take parameter LOG2_DATA_WIDTH, default 3, width of bit index.
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-007 SHALL have port start  input  1  begin sort-readout of all UM entries; ignored unless IDLE.
REQ-008 SHALL have port bit_data  input  ELEMENT_NUM  UM bit-plane at bit_addr, MSB plane already inverted by UM, combinational same cycle.
REQ-009 SHALL have port um_data  input  DATA_WIDTH  UM word at um_addr, combinational same cycle.
REQ-010 SHALL have port bit_addr  output  LOG2_DATA_WIDTH  registered bit-plane select.
REQ-011 SHALL have port um_addr  output  LOG2_ELEMENT_NUM  registered word select.
REQ-012 SHALL have port out_valid  output  1  out_data/out_idx hold the next sorted element.
REQ-013 SHALL have port out_ready  input  1  consumer accepts; transfer when out_valid && out_ready.
REQ-014 SHALL have port out_data  output  DATA_WIDTH  sorted element value, registered.
REQ-015 SHALL have port out_idx  output  LOG2_ELEMENT_NUM  UM index of out_data, registered.
REQ-016 SHALL have port busy  output  1  high in any state except IDLE.
REQ-017 SHALL have port done  output  1  one-cycle pulse after last transfer.

Function
REQ-018 SHALL implement FSM IDLE, SCAN, LOAD, EMIT, DONE.
REQ-019 IDLE: start=1 SHALL set remaining and mask to all-ones, count to 0, bit_addr to DATA_WIDTH-1, go SCAN.
REQ-020 SCAN, each cycle: cand = mask & ~bit_data; if cand!=0 then mask<=cand else mask unchanged; bit_addr decrements.
REQ-021 SCAN at bit_addr==0: SHALL set um_addr to lowest set index of the updated mask (ties -> lowest index), go LOAD.
REQ-022 LOAD: SHALL capture um_data into out_data and um_addr into out_idx, go EMIT.
REQ-023 EMIT: out_valid SHALL be 1; out_data/out_idx SHALL be stable until transfer.
REQ-024 On transfer: clear out_idx in remaining, count++, out_valid<=0; if count==ELEMENT_NUM-1 go DONE, else mask<=remaining minus out_idx, bit_addr<=DATA_WIDTH-1, go SCAN.
REQ-025 DONE: done=1 for exactly one cycle, then IDLE.
REQ-026 Output order SHALL be ascending signed two's-complement; equal values SHALL emit in ascending index.
REQ-027 Latency: with start sampled in cycle 0, first out_valid SHALL rise in cycle DATA_WIDTH+2; each later element SHALL take DATA_WIDTH+2 cycles after the previous transfer.
REQ-028 start while busy SHALL be ignored; out_ready while not out_valid SHALL be ignored.
REQ-029 UM contents SHALL not be written while busy; behaviour otherwise undefined.

Reset
REQ-030 rst=0 at a clock edge SHALL force IDLE from any state, including mid-SCAN or EMIT.
REQ-031 Reset values: out_valid 0, done 0, busy 0, out_data 0, out_idx 0, um_addr 0, bit_addr 0, mask/remaining 0, count 0.

Structure
REQ-032 DATA_WIDTH, ELEMENT_NUM, LOG2_ELEMENT_NUM, LOG2_DATA_WIDTH and state encodings SHALL live in the shared parameter header.
REQ-033 Lowest-set-bit priority encoder SHALL be one sub-module, um_lsb_enc.

Verification (DATA_WIDTH=8, ELEMENT_NUM=16)
REQ-034 UM[i]=15-i, start -> out_data 0..15, out_idx 15..0, done one cycle after 16th transfer.
REQ-035 UM[0]=8'h80, UM[1]=8'h7F, rest 0 -> first 8'h80 idx 0, then fourteen 0x00 idx 2..15, last 8'h7F idx 1.
REQ-036 All UM=8'h05 -> out_idx 0,1,...,15 in order, all data 8'h05.
REQ-037 out_ready low 5 cycles at first EMIT -> out_valid, out_data, out_idx held, no advance; transfer on ready.
REQ-038 rst low at cycle 3 of SCAN -> next cycle busy 0, out_valid 0; subsequent start yields full correct sequence.
REQ-039 start pulsed during EMIT -> ignored, sequence and count unaffected; first out_valid at cycle 10 after start.
